// File: rtl/cpu.sv
// cpu: hardwired control unit for a console-driven teaching CPU.
// Ports:
//   t3          clock, state updates on rising edge
//   clr         synchronous active-low reset
//   swc/swb/swa console mode {swc,swb,swa}
//   ir[7:0]     instruction register, opcode in ir[7:4]
//   w1/w2/w3    machine-cycle beats
//   c, z        carry / zero flags
//   outputs     datapath control strobes, s ALU select, sel3..sel0 register selects
// Define CPU_EXT_INSTR_EN to decode OUT (1010) and OR (1011).
module cpu (
   input  logic       t3,
   input  logic       clr,
   input  logic       swc,
   input  logic       swb,
   input  logic       swa,
   input  logic [7:0] ir,
   input  logic       w1,
   input  logic       w2,
   input  logic       w3,
   input  logic       c,
   input  logic       z,
   output logic       drw,
   output logic       pcinc,
   output logic       lpc,
   output logic       lar,
   output logic       pcadd,
   output logic       arinc,
   output logic       selctl,
   output logic       memw,
   output logic       stop,
   output logic       lir,
   output logic       ldz,
   output logic       ldc,
   output logic       cin,
   output logic       m,
   output logic       abus,
   output logic       sbus,
   output logic       mbus,
   output logic       short,
   output logic       long,
   output logic [3:0] s,
   output logic       sel3,
   output logic       sel2,
   output logic       sel1,
   output logic       sel0
);
   logic       r_st0;
   logic [2:0] w_sw;
   logic [3:0] w_op;
   logic       w_set;
   logic       w_unused;
   assign w_sw     = {swc, swb, swa};
   assign w_op     = ir[7:4];
   assign w_unused = ^ir[3:0];
   // st0 marks "first pass done": register bank high half, address loaded, or PC loaded
   assign w_set = !r_st0 && ((w_sw == 3'b100 && w2) ||
                  ((w_sw == 3'b001 || w_sw == 3'b010 || w_sw == 3'b000) && w1));
   always_ff @(posedge t3) begin
      if (!clr) r_st0 <= 1'b0;
      else if (w_set) r_st0 <= 1'b1;
   end
   always_comb begin
      {drw, pcinc, lpc, lar, pcadd, arinc, selctl, memw, stop, lir} = '0;
      {ldz, ldc, cin, m, abus, sbus, mbus, short, long} = '0;
      s = 4'b0000;
      {sel3, sel2, sel1, sel0} = 4'b0000;
      if (clr) begin
         case (w_sw)
            3'b100: if (w1 || w2) begin
               {sbus, drw, selctl, stop} = 4'b1111;
               {sel3, sel2} = {r_st0, w2};
            end
            3'b011: if (w1 || w2) begin
               {selctl, stop} = 2'b11;
               {sel3, sel2, sel1, sel0} = w2 ? 4'b1011 : 4'b0001;
            end
            3'b001, 3'b010: if (w1) begin
               {stop, short, selctl} = 3'b111;
               // swa distinguishes write-memory from read-memory on the second pass
               sbus  = !r_st0 || swa;
               lar   = !r_st0;
               arinc = r_st0;
               memw  = r_st0 && swa;
               mbus  = r_st0 && swb;
            end
            3'b000: if (!r_st0) begin
               if (w1) {sbus, lpc, short, stop} = 4'b1111;
            end else if (w1) begin
               {lir, pcinc} = 2'b11;
            end else if (w2) begin
               case (w_op)
                  4'b0001: begin s = 4'b1001; {cin, abus, drw, ldz, ldc} = 5'b11111; end
                  4'b0010: begin s = 4'b0110; {abus, drw, ldz, ldc} = 4'b1111; end
                  4'b0011: begin s = 4'b1011; {m, abus, drw, ldz} = 4'b1111; end
                  4'b0100: {abus, drw, ldz, ldc} = 4'b1111;
                  4'b0101: begin s = 4'b1010; {m, abus, lar, long} = 4'b1111; end
                  4'b0110: begin s = 4'b1111; {m, abus, lar, long} = 4'b1111; end
                  4'b0111: pcadd = c;
                  4'b1000: pcadd = z;
                  4'b1001: begin s = 4'b1111; {m, abus, lpc} = 3'b111; end
                  4'b1110: stop = 1'b1;
`ifdef CPU_EXT_INSTR_EN
                  4'b1010: begin s = 4'b1010; {m, abus} = 2'b11; end
                  4'b1011: begin s = 4'b1110; {m, abus, drw, ldz} = 4'b1111; end
`endif
                  default: ;
               endcase
            end else if (w3) begin
               case (w_op)
                  4'b0101: {drw, mbus} = 2'b11;
                  4'b0110: begin s = 4'b1010; {m, abus, memw} = 3'b111; end
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_cpu.sv
// tb_cpu: table-driven scoreboard bench for the cpu control unit.
module tb_cpu;
   logic       t3 = 1'b0, clr = 1'b0, swc = 1'b0, swb = 1'b0, swa = 1'b0;
   logic [7:0] ir = '0;
   logic       w1 = 1'b0, w2 = 1'b0, w3 = 1'b0, c = 1'b0, z = 1'b0;
   logic drw, pcinc, lpc, lar, pcadd, arinc, selctl, memw, stop, lir;
   logic ldz, ldc, cin, m, abus, sbus, mbus, short, long;
   logic [3:0] s;
   logic sel3, sel2, sel1, sel0;
   logic [26:0] got;
   logic [26:0] q[$];
   int n_vec = 0, n_bad = 0;

   localparam logic [26:0] DRW = 27'd1 << 26, PCINC = 27'd1 << 25, LPC = 27'd1 << 24;
   localparam logic [26:0] LAR = 27'd1 << 23, PCADD = 27'd1 << 22, ARINC = 27'd1 << 21;
   localparam logic [26:0] SELCTL = 27'd1 << 20, MEMW = 27'd1 << 19, STOP = 27'd1 << 18;
   localparam logic [26:0] LIR = 27'd1 << 17, LDZ = 27'd1 << 16, LDC = 27'd1 << 15;
   localparam logic [26:0] CIN = 27'd1 << 14, MM = 27'd1 << 13, ABUS = 27'd1 << 12;
   localparam logic [26:0] SBUS = 27'd1 << 11, MBUS = 27'd1 << 10, SHORT = 27'd1 << 9;
   localparam logic [26:0] LONG = 27'd1 << 8;
   localparam logic [26:0] MR = SBUS | DRW | SELCTL | STOP;
   localparam logic [26:0] MEM0 = SBUS | LAR | STOP | SHORT | SELCTL;
   localparam logic [26:0] BOOT = SBUS | LPC | SHORT | STOP;

   function automatic logic [26:0] sf(input logic [3:0] x);
      return {19'd0, x, 4'd0};
   endfunction
   function automatic logic [26:0] sl(input logic [3:0] x);
      return {23'd0, x};
   endfunction

   typedef struct {
      logic        cl;
      logic        st;
      logic [2:0]  sw;
      logic [3:0]  op;
      logic [2:0]  w;
      logic        cc;
      logic        zz;
      logic [26:0] exp;
      string       name;
   } vec_t;
   vec_t vt[$];

   always #5 t3 = ~t3;

   cpu dut (
      .t3(t3), .clr(clr), .swc(swc), .swb(swb), .swa(swa), .ir(ir),
      .w1(w1), .w2(w2), .w3(w3), .c(c), .z(z),
      .drw(drw), .pcinc(pcinc), .lpc(lpc), .lar(lar), .pcadd(pcadd),
      .arinc(arinc), .selctl(selctl), .memw(memw), .stop(stop), .lir(lir),
      .ldz(ldz), .ldc(ldc), .cin(cin), .m(m), .abus(abus), .sbus(sbus),
      .mbus(mbus), .short(short), .long(long), .s(s),
      .sel3(sel3), .sel2(sel2), .sel1(sel1), .sel0(sel0)
   );

   assign got = {drw, pcinc, lpc, lar, pcadd, arinc, selctl, memw, stop, lir,
                 ldz, ldc, cin, m, abus, sbus, mbus, short, long, s,
                 sel3, sel2, sel1, sel0};

   task automatic drive(input logic cl, input logic [2:0] sw, input logic [3:0] op,
                        input logic [2:0] w, input logic cc, input logic zz,
                        input logic [26:0] e);
      clr = cl;
      {swc, swb, swa} = sw;
      ir = {op, 4'($urandom())};
      {w1, w2, w3} = w;
      c = cc;
      z = zz;
      q.push_back(e);
   endtask

   task automatic check(input string nm);
      logic [26:0] e;
      #1;
      n_vec++;
      if (q.size() == 0) begin
         n_bad++;
         $display("FAIL %s: scoreboard empty, got %h", nm, got);
      end else begin
         e = q.pop_front();
         if (got !== e) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, got, e);
         end
      end
   endtask

   // Leaves st0 at the requested value, ending on a falling edge.
   task automatic setup(input logic st);
      @(negedge t3);
      clr = 1'b0;
      {w1, w2, w3} = 3'b000;
      {swc, swb, swa} = 3'b000;
      @(negedge t3);
      clr = 1'b1;
      if (st) begin
         w1 = 1'b1;
         @(negedge t3);
         w1 = 1'b0;
      end
   endtask

   initial begin
      vt.push_back('{1'b0, 1'b1, 3'b000, 4'b0001, 3'b010, 1'b0, 1'b0, 27'd0, "rst_forces_zero"});
      vt.push_back('{1'b1, 1'b0, 3'b000, 4'b0000, 3'b100, 1'b0, 1'b0, BOOT, "run_boot"});
      vt.push_back('{1'b1, 1'b1, 3'b000, 4'b0000, 3'b100, 1'b0, 1'b0, LIR | PCINC, "fetch"});
      vt.push_back('{1'b1, 1'b1, 3'b000, 4'b0001, 3'b010, 1'b0, 1'b0, sf(4'b1001) | CIN | ABUS | DRW | LDZ | LDC, "add"});
      vt.push_back('{1'b1, 1'b1, 3'b000, 4'b0010, 3'b010, 1'b0, 1'b0, sf(4'b0110) | ABUS | DRW | LDZ | LDC, "sub"});
      vt.push_back('{1'b1, 1'b1, 3'b000, 4'b0011, 3'b010, 1'b0, 1'b0, sf(4'b1011) | MM | ABUS | DRW | LDZ, "and"});
      vt.push_back('{1'b1, 1'b1, 3'b000, 4'b0100, 3'b010, 1'b0, 1'b0, ABUS | DRW | LDZ | LDC, "inc"});
      vt.push_back('{1'b1, 1'b1, 3'b000, 4'b0101, 3'b010, 1'b0, 1'b0, sf(4'b1010) | MM | ABUS | LAR | LONG, "ld_w2"});
      vt.push_back('{1'b1, 1'b1, 3'b000, 4'b0101, 3'b001, 1'b0, 1'b0, DRW | MBUS, "ld_w3"});
      vt.push_back('{1'b1, 1'b1, 3'b000, 4'b0110, 3'b010, 1'b0, 1'b0, sf(4'b1111) | MM | ABUS | LAR | LONG, "st_w2"});
      vt.push_back('{1'b1, 1'b1, 3'b000, 4'b0110, 3'b001, 1'b0, 1'b0, sf(4'b1010) | MM | ABUS | MEMW, "st_w3"});
      vt.push_back('{1'b1, 1'b1, 3'b000, 4'b0111, 3'b010, 1'b0, 1'b1, 27'd0, "jc_c0"});
      vt.push_back('{1'b1, 1'b1, 3'b000, 4'b0111, 3'b010, 1'b1, 1'b0, PCADD, "jc_c1"});
      vt.push_back('{1'b1, 1'b1, 3'b000, 4'b1000, 3'b010, 1'b1, 1'b0, 27'd0, "jz_z0"});
      vt.push_back('{1'b1, 1'b1, 3'b000, 4'b1000, 3'b010, 1'b0, 1'b1, PCADD, "jz_z1"});
      vt.push_back('{1'b1, 1'b1, 3'b000, 4'b1001, 3'b010, 1'b0, 1'b0, sf(4'b1111) | MM | ABUS | LPC, "jmp"});
      vt.push_back('{1'b1, 1'b1, 3'b000, 4'b1110, 3'b010, 1'b0, 1'b0, STOP, "stp"});
      vt.push_back('{1'b1, 1'b1, 3'b000, 4'b0000, 3'b010, 1'b1, 1'b1, 27'd0, "nop_0000"});
      vt.push_back('{1'b1, 1'b1, 3'b000, 4'b1100, 3'b010, 1'b1, 1'b1, 27'd0, "nop_1100"});
      vt.push_back('{1'b1, 1'b1, 3'b000, 4'b1111, 3'b010, 1'b1, 1'b1, 27'd0, "nop_1111"});
      vt.push_back('{1'b1, 1'b1, 3'b000, 4'b0001, 3'b001, 1'b0, 1'b0, 27'd0, "add_w3_idle"});
`ifdef CPU_EXT_INSTR_EN
      vt.push_back('{1'b1, 1'b1, 3'b000, 4'b1010, 3'b010, 1'b0, 1'b0, sf(4'b1010) | MM | ABUS, "out"});
      vt.push_back('{1'b1, 1'b1, 3'b000, 4'b1011, 3'b010, 1'b0, 1'b0, sf(4'b1110) | MM | ABUS | DRW | LDZ, "or"});
`else
      vt.push_back('{1'b1, 1'b1, 3'b000, 4'b1010, 3'b010, 1'b0, 1'b0, 27'd0, "nop_1010"});
      vt.push_back('{1'b1, 1'b1, 3'b000, 4'b1011, 3'b010, 1'b0, 1'b0, 27'd0, "nop_1011"});
`endif
      vt.push_back('{1'b1, 1'b0, 3'b011, 4'b0000, 3'b100, 1'b0, 1'b0, SELCTL | STOP | sl(4'b0001), "rdreg_w1"});
      vt.push_back('{1'b1, 1'b0, 3'b011, 4'b0000, 3'b010, 1'b0, 1'b0, SELCTL | STOP | sl(4'b1011), "rdreg_w2"});
      vt.push_back('{1'b1, 1'b0, 3'b100, 4'b0000, 3'b100, 1'b0, 1'b0, MR | sl(4'b0000), "wrreg_s0_w1"});
      vt.push_back('{1'b1, 1'b0, 3'b100, 4'b0000, 3'b010, 1'b0, 1'b0, MR | sl(4'b0100), "wrreg_s0_w2"});
      vt.push_back('{1'b1, 1'b1, 3'b100, 4'b0000, 3'b100, 1'b0, 1'b0, MR | sl(4'b1000), "wrreg_s1_w1"});
      vt.push_back('{1'b1, 1'b1, 3'b100, 4'b0000, 3'b010, 1'b0, 1'b0, MR | sl(4'b1100), "wrreg_s1_w2"});
      vt.push_back('{1'b1, 1'b0, 3'b001, 4'b0000, 3'b100, 1'b0, 1'b0, MEM0, "wrmem_s0"});
      vt.push_back('{1'b1, 1'b1, 3'b001, 4'b0000, 3'b100, 1'b0, 1'b0, SBUS | MEMW | ARINC | STOP | SHORT | SELCTL, "wrmem_s1"});
      vt.push_back('{1'b1, 1'b0, 3'b010, 4'b0000, 3'b100, 1'b0, 1'b0, MEM0, "rdmem_s0"});
      vt.push_back('{1'b1, 1'b1, 3'b010, 4'b0000, 3'b100, 1'b0, 1'b0, MBUS | ARINC | STOP | SHORT | SELCTL, "rdmem_s1"});
      vt.push_back('{1'b1, 1'b1, 3'b101, 4'b0001, 3'b110, 1'b0, 1'b0, 27'd0, "mode101"});
      vt.push_back('{1'b1, 1'b1, 3'b110, 4'b0001, 3'b110, 1'b0, 1'b0, 27'd0, "mode110"});
      vt.push_back('{1'b1, 1'b0, 3'b111, 4'b0001, 3'b100, 1'b0, 1'b0, 27'd0, "mode111"});
      vt.push_back('{1'b1, 1'b1, 3'b100, 4'b0000, 3'b000, 1'b0, 1'b0, 27'd0, "no_beat_wrreg"});
      vt.push_back('{1'b1, 1'b0, 3'b000, 4'b0001, 3'b000, 1'b0, 1'b0, 27'd0, "no_beat_run"});

      foreach (vt[i]) begin
         setup(vt[i].st);
         drive(vt[i].cl, vt[i].sw, vt[i].op, vt[i].w, vt[i].cc, vt[i].zz, vt[i].exp);
         check(vt[i].name);
      end

      // boot sequence: reset, load PC, then fetch on the next w1
      @(negedge t3);
      drive(1'b0, 3'b000, 4'b0000, 3'b100, 1'b0, 1'b0, 27'd0);
      check("seq_boot_rst");
      @(negedge t3);
      drive(1'b1, 3'b000, 4'b0000, 3'b100, 1'b0, 1'b0, BOOT);
      check("seq_boot_w1");
      @(negedge t3);
      drive(1'b1, 3'b000, 4'b0000, 3'b100, 1'b0, 1'b0, LIR | PCINC);
      check("seq_boot_fetch");

      // read memory: address load, then successive reads
      setup(1'b0);
      drive(1'b1, 3'b010, 4'b0000, 3'b100, 1'b0, 1'b0, MEM0);
      check("seq_rdmem_1");
      @(negedge t3);
      drive(1'b1, 3'b010, 4'b0000, 3'b100, 1'b0, 1'b0, MBUS | ARINC | STOP | SHORT | SELCTL);
      check("seq_rdmem_2");

      // write registers: st0 flips only after the w2 beat
      setup(1'b0);
      drive(1'b1, 3'b100, 4'b0000, 3'b100, 1'b0, 1'b0, MR | sl(4'b0000));
      check("seq_wrreg_a");
      @(negedge t3);
      drive(1'b1, 3'b100, 4'b0000, 3'b010, 1'b0, 1'b0, MR | sl(4'b0100));
      check("seq_wrreg_b");
      @(negedge t3);
      drive(1'b1, 3'b100, 4'b0000, 3'b100, 1'b0, 1'b0, MR | sl(4'b1000));
      check("seq_wrreg_c");
      @(negedge t3);
      drive(1'b1, 3'b100, 4'b0000, 3'b010, 1'b0, 1'b0, MR | sl(4'b1100));
      check("seq_wrreg_d");

      // st0 survives an excursion through an idle mode
      setup(1'b1);
      drive(1'b1, 3'b101, 4'b0000, 3'b100, 1'b0, 1'b0, 27'd0);
      check("seq_hold_101");
      @(negedge t3);
      drive(1'b1, 3'b100, 4'b0000, 3'b100, 1'b0, 1'b0, MR | sl(4'b1000));
      check("seq_hold_st0");

      // reset mid-instruction blanks outputs and clears st0
      setup(1'b1);
      drive(1'b0, 3'b000, 4'b0110, 3'b001, 1'b0, 1'b0, 27'd0);
      check("seq_rst_mid");
      @(negedge t3);
      drive(1'b1, 3'b000, 4'b0000, 3'b100, 1'b0, 1'b0, BOOT);
      check("seq_rst_clears_st0");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/cpu.md
CPU -- requirements
Module: cpu

Interface
REQ-001 SHALL have these ports (clock and reset first):
- t3  input  1  clock; all state updates on the rising edge.
- clr  input  1  reset, synchronous, active-low.
- swc, swb, swa  input  1 each  console mode switches {swc,swb,swa}.
- ir  input  8  instruction register; only ir[7:4] is decoded.
- w1, w2, w3  input  1 each  machine-cycle beat pulses.
- c, z  input  1 each  carry and zero flags.
- drw, pcinc, lpc, lar, pcadd, arinc, selctl, memw, stop, lir, ldz, ldc, cin, m, abus, sbus, mbus, short, long  output  1 each  datapath control strobes.
- s  output  4  ALU function select.
- sel3, sel2, sel1, sel0  output  1 each  register selects: sel3:sel2 = destination/A, sel1:sel0 = source/B.
REQ-002 SHALL hold one internal state bit st0; every output SHALL be combinational from the inputs and st0.

Function
REQ-003 Any output not asserted by a rule below SHALL be 0, with s=0000.
REQ-004 Mode 100 (write register): sbus, drw, selctl, stop on w1 and w2; w1 sel3:sel2={st0,0}, w2 sel3:sel2={st0,1}; st0 sets at a t3 edge with w2=1 and st0=0.
REQ-005 Mode 011 (read register): selctl and stop; w1 sel3..sel0=0001, w2 sel3..sel0=1011.
REQ-006 Mode 001 (write memory): w1 with st0=0 gives sbus, lar, stop, short, selctl and sets st0 at the t3 edge; w1 with st0=1 gives sbus, memw, arinc, stop, short, selctl.
REQ-007 Mode 010 (read memory): as REQ-006, except w1 with st0=1 gives mbus, arinc, stop, short, selctl.
REQ-008 Mode 000 (run): w1 with st0=0 gives sbus, lpc, short, stop and sets st0; with st0=1, w1 gives lir and pcinc (fetch), and w2/w3 execute as in REQ-009.
REQ-009 Execute, by ir[7:4]:
- 0001 ADD: w2 s=1001, cin, abus, drw, ldz, ldc.
- 0010 SUB: w2 s=0110, abus, drw, ldz, ldc.
- 0011 AND: w2 m, s=1011, abus, drw, ldz.
- 0100 INC: w2 s=0000, abus, drw, ldz, ldc.
- 0101 LD: w2 m, s=1010, abus, lar, long; w3 drw, mbus.
- 0110 ST: w2 m, s=1111, abus, lar, long; w3 m, s=1010, abus, memw.
- 0111 JC: w2 pcadd only if c=1.
- 1000 JZ: w2 pcadd only if z=1.
- 1001 JMP: w2 m, s=1111, abus, lpc.
- 1110 STP: w2 stop.
- All other codes: NOP, w2 with no outputs.
REQ-010 Modes 101, 110, 111: all outputs 0; st0 is held.
REQ-011 st0 SHALL change only under REQ-004/006/007/008 or reset; a switch change does not clear it.
REQ-012 If w1, w2 and w3 are all 0, all outputs SHALL be 0.

Reset
REQ-013 At a t3 rising edge with clr=0, st0 SHALL become 0.
REQ-014 While clr=0, every output SHALL be driven 0 combinationally, including mid-instruction.

Configuration
REQ-015 With macro CPU_EXT_INSTR_EN defined, two extra instructions SHALL be decoded:
- 1010 OUT: w2 m, s=1010, abus.
- 1011 OR: w2 m, s=1110, abus, drw, ldz.
Without the macro, 1010 and 1011 SHALL be NOPs.

Verification
REQ-016 clr=0 for one t3 edge, then mode 000 with w1=1 -> sbus=lpc=short=stop=1; st0=1 after the t3 edge; the next w1 gives lir=pcinc=1.
REQ-017 Mode 000, st0=1, ir=00010000, w2=1 -> s=1001, cin=abus=drw=ldz=ldc=1, m=0.
REQ-018 Mode 000, st0=1, ir=01100000: w2 -> lar=long=abus=m=1, s=1111; w3 -> memw=1, s=1010.
REQ-019 Mode 000, ir=01110000, w2=1, c=0 -> pcadd=0; with c=1 -> pcadd=1.
REQ-020 Mode 010 (swb=1): first w1 -> lar=short=stop=1; second w1 -> mbus=arinc=1, lar=0.
REQ-021 Mode 100: w1 then w2 with st0=0 -> sel3:sel2=00 then 01; st0=1 afterwards; the next pass gives 10 then 11.
